bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  conversion request, sampled on rising clk.
REQ-005 bin  input  14  unsigned binary value, sampled only when start is accepted.
REQ-006 bcd  output  16  four packed BCD digits; [15:12] thousands, [3:0] units; each digit feeds one 7-segment decoder.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse marking bcd as newly valid.
REQ-009 ovf  output  1  input exceeded 9999; present only with BCD_OVF_EN.

Function
REQ-010 Algorithm SHALL be shift-and-add-3 (double dabble), one bit per clock, MSB first.
REQ-011 FSM SHALL have two states: IDLE and SHIFT, encoded 1'b0 and 1'b1.
REQ-012 IDLE with start=1 at edge E0: latch bin into the shift register; clear the scratch digits and the 4-bit iteration counter; set busy=1; go to SHIFT.
REQ-013 Each SHIFT edge SHALL apply the add-3 step to every scratch digit ≥5, then shift {digits, bin} left by one and increment the counter.
REQ-014 At the 14th SHIFT edge (E14): load bcd with the final digits; set done=1; clear busy; return to IDLE.
REQ-015 Latency SHALL be exactly 14 cycles: done and the new bcd are visible in the cycle after E14.
REQ-016 done SHALL clear at E15 under all conditions, including acceptance of a new start at E15.
REQ-017 start during SHIFT SHALL be ignored; it is not queued, and bin changes during SHIFT SHALL have no effect.
REQ-018 start is accepted at E15, the first IDLE edge after E14, which gives back-to-back conversions 15 cycles apart.
REQ-019 bcd SHALL hold its value between done pulses; it does not change during a conversion.
REQ-020 Scratch digit width SHALL be 16 bits; any carry out of the thousands digit SHALL be discarded.

Reset
REQ-021 rst_n low SHALL immediately force: state=IDLE, counter=0, shift register=0, bcd=16'h0000, busy=0, done=0, ovf=0.
REQ-022 Reset mid-conversion SHALL abort the conversion with no done pulse; the first start after release begins a fresh conversion.
REQ-023 Reset release is synchronous to clk; start is honoured from the first edge with rst_n high.

Configuration
REQ-024 Macro BCD_OVF_EN.
REQ-025 When BCD_OVF_EN is defined:
- An input >9999 SHALL be detected at acceptance and registered.
- At E14, bcd SHALL be 16'h9999 (saturated) and ovf=1.
- ovf SHALL otherwise be 0 and SHALL update only at E14.
REQ-026 When BCD_OVF_EN is undefined:
- The ovf port and its logic SHALL be absent.
- bcd SHALL equal bin mod 10000 in BCD, as REQ-020 implies.

Structure
REQ-027 Shared package bcd_pkg SHALL hold:
- State encodings.
- Widths BIN_W=14, DIG_N=4, BCD_W=16.
- Iteration count 14.
- Saturation constants 9999 and 16'h9999.
REQ-028 Sub-module bcd_add3 SHALL be a combinational 4-bit "add 3 if ≥5" cell, instantiated DIG_N times.

Verification
REQ-029 bin=0, start pulse → done after 14 cycles, bcd=16'h0000, busy high for exactly 14 cycles.
REQ-030 bin=1234, then bin=9999 back-to-back, with the second start at the done cycle's next edge → bcd=16'h1234, then bcd=16'h9999; the two done pulses are 15 cycles apart.
REQ-031 Start accepted with bin=4321; start re-pulsed at cycle 5 with bin=0007 → single done at cycle 14 with bcd=16'h4321.
REQ-032 Start with bin=5678; rst_n low at cycle 7 for 2 cycles → outputs zero immediately, no done; a fresh start with bin=0042 → bcd=16'h0042 after 14 cycles.
REQ-033 bin=12345 → with BCD_OVF_EN: bcd=16'h9999, ovf=1; without: bcd=16'h2345. Then bin=10 → bcd=16'h0010, ovf=0.
REQ-034 Exhaustive sweep 0–9999 against a reference model → every bcd digit ≤9 and equal to the decimal value.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: FSM encodings,
// datapath widths, iteration count and saturation values.
package bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int BIN_W = 14;
  localparam int DIG_N = 4;
  localparam int BCD_W = 16;

  localparam logic [3:0]       ITER_N  = 4'd14;
  localparam logic [BIN_W-1:0] SAT_BIN = 14'd9999;
  localparam logic [BCD_W-1:0] SAT_BCD = 16'h9999;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, one bit per clock, MSB first.
// Optional BCD_OVF_EN adds the ovf port and saturates inputs above 9999 to 16'h9999.
module bin_to_bcd_seq
  import bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done
`ifdef BCD_OVF_EN
  ,
  output logic        ovf
`endif
);

  state_t             state_reg;
  state_t             state_next;
  logic [3:0]         cnt_reg;
  logic [BIN_W-1:0]   sr_reg;
  logic [BCD_W-1:0]   dig_reg;
  logic [BCD_W-1:0]   dig_adj;
  logic [BCD_W-1:0]   dig_next;
  logic [BIN_W-1:0]   sr_next;
  logic [BCD_W-1:0]   bcd_reg;
  logic               done_reg;
  logic               accept;
  logic               last;

  genvar gi;
  generate
    for (gi = 0; gi < DIG_N; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (dig_reg[4*gi +: 4]),
        .dout (dig_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Shift {digits, binary} left by one; the bit leaving the thousands digit is dropped.
  assign dig_next = {dig_adj[BCD_W-2:0], sr_reg[BIN_W-1]};
  assign sr_next  = {sr_reg[BIN_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last)  state_next = ST_IDLE;
      default:             state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    last   = 1'b0;
    busy   = 1'b0;
    case (state_reg)
      ST_IDLE:  accept = start;
      ST_SHIFT: begin
        busy = 1'b1;
        last = (cnt_reg == ITER_N - 4'd1);
      end
      default: ;
    endcase
  end

`ifdef BCD_OVF_EN
  logic ovf_pend_reg;
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (accept) ovf_pend_reg <= (bin > SAT_BIN);
      if (last)   ovf_reg      <= ovf_pend_reg;
    end
  end

  assign ovf = ovf_reg;

  logic [BCD_W-1:0] bcd_final;
  assign bcd_final = ovf_pend_reg ? SAT_BCD : dig_next;
`else
  logic [BCD_W-1:0] bcd_final;
  assign bcd_final = dig_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= 4'd0;
      sr_reg   <= '0;
      dig_reg  <= '0;
      bcd_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        sr_reg  <= bin;
        dig_reg <= '0;
        cnt_reg <= 4'd0;
      end else if (busy) begin
        sr_reg  <= sr_next;
        dig_reg <= dig_next;
        cnt_reg <= cnt_reg + 4'd1;
        if (last) begin
          bcd_reg  <= bcd_final;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign bcd  = bcd_reg;
  assign done = done_reg;

endmodule
